vram_scanout: RTL and testbench

- Display-side reader for the VRAM primary port: generates 640x480 VGA timing, fetches the 512x256 1-bpp Hack screen from VRAM and serialises it to a pixel stream.
- Owns p_read/p_addr and consumes p_dout; the CPU keeps the secondary port.
- Keeps p_read to single-cycle pulses, one per 16 pixels, so the CPU stall (s_busy) stays short.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_timing.sv | 64 ++++++
 rtl/vram_scanout.sv | 123 ++++++++++++
 tb/tb_vram_scanout.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA 640x480 timing and Hack screen geometry constants
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int SCR_W         = 512;
    localparam int SCR_H         = 256;
    localparam int WORDS_PER_ROW = 32;
    localparam int ADDR_W        = 13;
    localparam int CNT_W         = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t wrap_inc(input cnt_t v, input int total);
        return (int'(v) == total - 1) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v counters with registered hsync, vsync and video_on
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS = vga_pkg::H_VISIBLE,
    parameter int H_FP  = vga_pkg::H_FRONT,
    parameter int H_SYN = vga_pkg::H_SYNC,
    parameter int H_BP  = vga_pkg::H_BACK,
    parameter int V_VIS = vga_pkg::V_VISIBLE,
    parameter int V_FP  = vga_pkg::V_FRONT,
    parameter int V_SYN = vga_pkg::V_SYNC,
    parameter int V_BP  = vga_pkg::V_BACK
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    output logic [CNT_W-1:0] h_count_o,
    output logic [CNT_W-1:0] v_count_o,
    output logic [CNT_W-1:0] h_next_o,
    output logic [CNT_W-1:0] v_next_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             video_on_o
);

    localparam int HT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYN + V_BP;

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             hsync_q, vsync_q, video_on_q;

    always_comb begin
        h_d = wrap_inc(h_q, HT);
        v_d = v_q;
        if (int'(h_q) == HT - 1) begin
            v_d = wrap_inc(v_q, VT);
        end
    end

    // Sync/video flags are registered from the current count, so they lag it by one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q        <= '0;
            v_q        <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            hsync_q    <= !((int'(h_q) >= H_VIS + H_FP) && (int'(h_q) < H_VIS + H_FP + H_SYN));
            vsync_q    <= !((int'(v_q) >= V_VIS + V_FP) && (int'(v_q) < V_VIS + V_FP + V_SYN));
            video_on_q <= (int'(h_q) < H_VIS) && (int'(v_q) < V_VIS);
        end
    end

    assign h_count_o  = h_q;
    assign v_count_o  = v_q;
    assign h_next_o   = h_d;
    assign v_next_o   = v_d;
    assign hsync_o    = hsync_q;
    assign vsync_o    = vsync_q;
    assign video_on_o = video_on_q;

endmodule

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VGA scanout of the 512x256 1-bpp screen from the VRAM primary port
module vram_scanout
    import vga_pkg::*;
#(
    parameter int H_VIS      = vga_pkg::H_VISIBLE,
    parameter int H_FP       = vga_pkg::H_FRONT,
    parameter int H_SYN      = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BACK,
    parameter int V_VIS      = vga_pkg::V_VISIBLE,
    parameter int V_FP       = vga_pkg::V_FRONT,
    parameter int V_SYN      = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BACK,
    parameter int WIN_X      = 64,
    parameter int WIN_Y      = 112,
    parameter int LATENCY    = 3,
    parameter int FETCH_LEAD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              p_read,
    output logic [ADDR_W-1:0] p_addr,
    input  logic [15:0]       p_dout,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic              pixel
);

    localparam int HT = H_VIS + H_FP + H_SYN + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYN + V_BP;

    logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;

    vga_timing #(
        .H_VIS (H_VIS),
        .H_FP  (H_FP),
        .H_SYN (H_SYN),
        .H_BP  (H_BP),
        .V_VIS (V_VIS),
        .V_FP  (V_FP),
        .V_SYN (V_SYN),
        .V_BP  (V_BP)
    ) u_timing (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .h_count_o  (h_cnt),
        .v_count_o  (v_cnt),
        .h_next_o   (h_nxt),
        .v_next_o   (v_nxt),
        .hsync_o    (hsync),
        .vsync_o    (vsync),
        .video_on_o (video_on)
    );

    logic              p_read_q;
    logic [ADDR_W-1:0] p_addr_q;
    logic [LATENCY-1:0] rd_dly_q;
    logic [15:0]       stage_q;
    logic [15:0]       shift_q;
    logic              pixel_q;

    int   lead_h, lead_v, lead_col, lead_row;
    logic fetch_hit;

    // Request decode looks at the position FETCH_LEAD pixels past the next count, so a
    // lead that crosses the line end still targets the line where the word is shown.
    always_comb begin
        lead_h = int'(h_nxt) + FETCH_LEAD;
        lead_v = int'(v_nxt);
        if (lead_h >= HT) begin
            lead_h = lead_h - HT;
            lead_v = (lead_v == VT - 1) ? 0 : lead_v + 1;
        end
        lead_col  = lead_h - WIN_X;
        lead_row  = lead_v - WIN_Y;
        fetch_hit = (lead_row >= 0) && (lead_row < SCR_H) && (lead_v < V_VIS) &&
                    (lead_col >= 0) && (lead_col < SCR_W) && (lead_col[3:0] == 4'd0);
    end

    int          col, row;
    logic        in_win, load;
    logic [15:0] pix_word;

    always_comb begin
        col      = int'(h_cnt) - WIN_X;
        row      = int'(v_cnt) - WIN_Y;
        in_win   = (row >= 0) && (row < SCR_H) && (col >= 0) && (col < SCR_W) &&
                   (int'(h_cnt) < H_VIS) && (int'(v_cnt) < V_VIS);
        load     = in_win && (col[3:0] == 4'd0);
        pix_word = load ? stage_q : shift_q;
    end

    // The shifter loads and emits bit 0 in the same cycle so pixel stays aligned with hsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_read_q <= 1'b0;
            p_addr_q <= '0;
            rd_dly_q <= '0;
            stage_q  <= '0;
            shift_q  <= '0;
            pixel_q  <= 1'b0;
        end else begin
            p_read_q <= fetch_hit;
            if (fetch_hit) begin
                p_addr_q <= {lead_row[7:0], lead_col[8:4]};
            end
            rd_dly_q[0] <= p_read_q;
            for (int i = 1; i < LATENCY; i++) begin
                rd_dly_q[i] <= rd_dly_q[i-1];
            end
            if (rd_dly_q[LATENCY-1]) begin
                stage_q <= p_dout;
            end
            shift_q <= {1'b0, pix_word[15:1]};
            pixel_q <= in_win & pix_word[0];
        end
    end

    assign p_read = p_read_q;
    assign p_addr = p_addr_q;
    assign pixel  = pixel_q;

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - directed bench for vram_scanout, lead 4 and lead 16 instances
module tb_vram_scanout;

    localparam int TB_HT  = 800;
    localparam int TB_VIS = 6;
    localparam int TB_VT  = 9;
    localparam int TB_WY  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_read4, p_read16;
    logic [12:0] p_addr4, p_addr16;
    logic [15:0] p_dout4, p_dout16;
    logic        hsync4, vsync4, video_on4, pixel4;
    logic        hsync16, vsync16, video_on16, pixel16;

    logic [15:0] mem [8192];
    logic [15:0] d4_1, d4_2, d4_3, d16_1, d16_2, d16_3;

    int vectors = 0;
    int miscompares = 0;
    int tb_h = 0, tb_v = 0, ph = 0, pv = 0;
    bit prev_valid = 1'b0;
    int rd_cnt4 = 0, rd_cnt16 = 0, base4 = 0, base16 = 0;

    always #5 clk = ~clk;

    vram_scanout #(
        .V_VIS(TB_VIS), .V_FP(1), .V_SYN(1), .V_BP(1),
        .WIN_X(64), .WIN_Y(TB_WY), .LATENCY(3), .FETCH_LEAD(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .p_read(p_read4), .p_addr(p_addr4), .p_dout(p_dout4),
        .hsync(hsync4), .vsync(vsync4), .video_on(video_on4), .pixel(pixel4)
    );

    vram_scanout #(
        .V_VIS(TB_VIS), .V_FP(1), .V_SYN(1), .V_BP(1),
        .WIN_X(64), .WIN_Y(TB_WY), .LATENCY(3), .FETCH_LEAD(16)
    ) dut16 (
        .clk(clk), .rst_n(rst_n), .p_read(p_read16), .p_addr(p_addr16), .p_dout(p_dout16),
        .hsync(hsync16), .vsync(vsync16), .video_on(video_on16), .pixel(pixel16)
    );

    // VRAM model: data visible 3 cycles after the sampling edge, random filler otherwise.
    always @(posedge clk) begin
        d4_1  <= p_read4 ? mem[p_addr4] : 16'($urandom);
        d4_2  <= d4_1;
        d4_3  <= d4_2;
        d16_1 <= p_read16 ? mem[p_addr16] : 16'($urandom);
        d16_2 <= d16_1;
        d16_3 <= d16_2;
    end
    assign p_dout4  = d4_3;
    assign p_dout16 = d16_3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tb_h <= 0;
            tb_v <= 0;
            prev_valid <= 1'b0;
        end else begin
            ph <= tb_h;
            pv <= tb_v;
            prev_valid <= 1'b1;
            tb_h <= (tb_h == TB_HT - 1) ? 0 : tb_h + 1;
            if (tb_h == TB_HT - 1) tb_v <= (tb_v == TB_VT - 1) ? 0 : tb_v + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, tb_h, tb_v);
        end
    endtask

    function automatic bit exp_rd(input int h, input int v, input int lead);
        int c;
        c = h + lead - 64;
        return (v >= TB_WY) && (v < TB_VIS) && (c >= 0) && (c < 512) && (c % 16 == 0);
    endfunction

    function automatic int exp_addr(input int h, input int v, input int lead);
        return (v - TB_WY) * 32 + (h + lead - 64) / 16;
    endfunction

    function automatic bit exp_pix(input int h, input int v);
        logic [15:0] w;
        if (v < TB_WY || v >= TB_VIS || h < 64 || h >= 576) return 1'b0;
        w = mem[(v - TB_WY) * 32 + (h - 64) / 16];
        return w[(h - 64) % 16];
    endfunction

    always @(negedge clk) begin
        check("p_read_lead4", 32'(p_read4), 32'(exp_rd(tb_h, tb_v, 4)));
        check("p_read_lead16", 32'(p_read16), 32'(exp_rd(tb_h, tb_v, 16)));
        if (exp_rd(tb_h, tb_v, 4)) check("p_addr_lead4", 32'(p_addr4), 32'(exp_addr(tb_h, tb_v, 4)));
        if (exp_rd(tb_h, tb_v, 16)) check("p_addr_lead16", 32'(p_addr16), 32'(exp_addr(tb_h, tb_v, 16)));
        if (p_read4) rd_cnt4++;
        if (p_read16) rd_cnt16++;
        if (prev_valid) begin
            check("hsync", 32'(hsync4), 32'(!(ph >= 656 && ph < 752)));
            check("hsync_lead16", 32'(hsync16), 32'(!(ph >= 656 && ph < 752)));
            check("vsync", 32'(vsync4), 32'(pv != 7));
            check("video_on", 32'(video_on4), 32'(ph < 640 && pv < TB_VIS));
            check("pixel_lead4", 32'(pixel4), 32'(exp_pix(ph, pv)));
            check("pixel_lead16", 32'(pixel16), 32'(exp_pix(ph, pv)));
        end else begin
            check("rst_hsync", 32'(hsync4), 32'd1);
            check("rst_vsync", 32'(vsync4), 32'd1);
            check("rst_video_on", 32'(video_on4), 32'd0);
            check("rst_pixel", 32'(pixel4), 32'd0);
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[0]   = 16'h0001;
        mem[37]  = 16'h8000;
        mem[70]  = 16'h00FF;
        mem[127] = 16'hA5A5;

        repeat (5) @(negedge clk);
        check("rst_p_addr", 32'(p_addr4), 32'd0);
        #2 rst_n = 1'b1;

        // Frame 1: sparse pattern
        repeat (TB_HT * TB_VT) @(posedge clk);
        @(negedge clk);
        check("reads_frame1_lead4", 32'(rd_cnt4 - base4), 32'd128);
        check("reads_frame1_lead16", 32'(rd_cnt16 - base16), 32'd128);
        base4 = rd_cnt4;
        base16 = rd_cnt16;

        // Frame 2: all ones
        for (int i = 0; i < 8192; i++) mem[i] = 16'hFFFF;
        repeat (TB_HT * TB_VT) @(posedge clk);
        @(negedge clk);
        check("reads_frame2_lead4", 32'(rd_cnt4 - base4), 32'd128);
        check("reads_frame2_lead16", 32'(rd_cnt16 - base16), 32'd128);

        // Frame 3: reset during the lead-4 fetch of row 2 word 15 (v=4, h=300)
        repeat (4 * TB_HT + 300) @(posedge clk);
        #2;
        check("pre_rst_p_read", 32'(p_read4), 32'd1);
        check("pre_rst_p_addr", 32'(p_addr4), 32'd79);
        check("pre_rst_video_on", 32'(video_on4), 32'd1);
        check("pre_rst_pixel", 32'(pixel4), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_p_read", 32'(p_read4), 32'd0);
        check("async_p_addr", 32'(p_addr4), 32'd0);
        check("async_p_addr_lead16", 32'(p_addr16), 32'd0);
        check("async_hsync", 32'(hsync4), 32'd1);
        check("async_vsync", 32'(vsync4), 32'd1);
        check("async_video_on", 32'(video_on4), 32'd0);
        check("async_pixel", 32'(pixel4), 32'd0);
        check("async_pixel_lead16", 32'(pixel16), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        base4 = rd_cnt4;
        base16 = rd_cnt16;
        repeat (TB_HT * TB_VT) @(posedge clk);
        @(negedge clk);
        check("reads_after_rst_lead4", 32'(rd_cnt4 - base4), 32'd128);
        check("reads_after_rst_lead16", 32'(rd_cnt16 - base16), 32'd128);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
